// File: rtl/stream_pkg.sv
// Shared definitions for the stream register-slice blocks.
//   skid_state_e         : occupancy state of the two-entry skid buffer
//   STALL_CNT_W_DEFAULT  : default width of the optional stall statistics counter
package stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int STALL_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, count -> 0
//   clr   : synchronous clear, wins over inc
//   inc   : add one this cycle unless already all-ones
//   count : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready register slice. Every handshake output (in_ready,
// out_valid, occupancy) and out_data comes straight from a flop, so neither
// the forward nor the backward handshake path crosses the slice
// combinationally. Sustains one transfer per cycle.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid/in_ready/in_data    : upstream stream
//   out_valid/out_ready/out_data : downstream stream
//   occupancy             : held entries, 0..2
//   stat_clr, stall_count : stall statistics (cycles with out_valid && !out_ready)
// Build option: define STREAM_SKID_STATS_EN to build the saturating stall
// counter; otherwise stall_count is tied to 0 and stat_clr is ignored.
module stream_skid_buffer
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int STALL_CNT_W = STALL_CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [1:0]             occupancy,
  input  logic                   stat_clr,
  output logic [STALL_CNT_W-1:0] stall_count
);

  skid_state_e           state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [1:0]            occupancy_q, occupancy_d;
  logic [DATA_WIDTH-1:0] out_reg, skid_reg;
  logic                  load_out_in, load_out_skid, load_skid;
  logic                  in_fire, out_fire;

  assign in_fire  = in_valid  && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    in_ready_d    = 1'b1;
    out_valid_d   = 1'b0;
    occupancy_d   = 2'd0;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_out_in = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_out_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          load_out_skid = 1'b1;
          state_d       = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Handshake outputs are decoded from the next state and registered,
    // which keeps them free of any same-cycle in_valid/out_ready path.
    case (state_d)
      BUSY: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b1;
        occupancy_d = 2'd1;
      end
      FULL: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        occupancy_d = 2'd2;
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        occupancy_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occupancy_q <= occupancy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg  <= '0;
      skid_reg <= '0;
    end else begin
      if (load_out_in) begin
        out_reg <= in_data;
      end else if (load_out_skid) begin
        out_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign occupancy = occupancy_q;
  assign out_data  = out_reg;

`ifdef STREAM_SKID_STATS_EN
  sat_counter #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (out_valid_q && !out_ready),
    .count (stall_count)
  );
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stall_count     = '0;
`endif

endmodule

// File: tb/tb_stream_skid_buffer.sv
module tb_stream_skid_buffer;

`ifdef STREAM_SKID_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        stat_clr = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_count;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_count;

  always #5 clk = ~clk;

  stream_skid_buffer #(.DATA_WIDTH(32), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stat_clr(stat_clr), .stall_count(stall_count)
  );

  // Narrow-counter instance sharing all inputs, for the saturation case.
  stream_skid_buffer #(.DATA_WIDTH(32), .STALL_CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stat_clr(stat_clr), .stall_count(s_stall_count)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of at most two entries plus a stall tally.
  logic [31:0] q[$];
  int          m_stall16 = 0;
  int          m_stall4  = 0;
  int          m_accepted = 0;
  bit          m_inf, m_outf, m_stall;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_stall16 = 0;
      m_stall4  = 0;
    end else begin
      m_inf   = in_valid && (q.size() < 2);
      m_outf  = out_ready && (q.size() > 0);
      m_stall = (q.size() > 0) && !out_ready;
      if (stat_clr) begin
        m_stall16 = 0;
        m_stall4  = 0;
      end else if (m_stall) begin
        if (m_stall16 < 65535) m_stall16++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (m_outf) void'(q.pop_front());
      if (m_inf) begin
        q.push_back(in_data);
        m_accepted++;
      end
    end
    #1;
    check("model_in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("model_out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("model_occupancy", 32'(occupancy), 32'(q.size()));
    if (q.size() > 0) check("model_out_data", out_data, q[0]);
    check("model_stall16", 32'(stall_count), STATS ? 32'(m_stall16) : 32'd0);
    check("model_stall4", 32'(s_stall_count), STATS ? 32'(m_stall4) : 32'd0);
  end

  task automatic drive(input bit v, input logic [31:0] d, input bit r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic ir, ov;
    logic [1:0] oc;
    int target, cyc;

    // Reset then idle
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_stall", 32'(stall_count), 32'd0);
    rst_n = 1'b1;

    // Streaming 1..8 with out_ready high
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 1'b1);
      tick();
      check("stream_data", out_data, 32'(i));
      check("stream_occ", 32'(occupancy), 32'd1);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    check("stream_drained", 32'(occupancy), 32'd0);

    // Skid fill: A held, B absorbed into skid
    drive(1'b1, 32'hA, 1'b1);
    tick();
    check("skid_busy_data", out_data, 32'hA);
    drive(1'b1, 32'hB, 1'b0);
    tick();
    check("skid_full_occ", 32'(occupancy), 32'd2);
    check("skid_full_in_ready", 32'(in_ready), 32'd0);
    check("skid_full_data", out_data, 32'hA);
    drive(1'b0, '0, 1'b0);
    tick();
    check("skid_hold_data", out_data, 32'hA);
    drive(1'b0, '0, 1'b1);
    tick();
    check("skid_emit_b", out_data, 32'hB);
    check("skid_recover_in_ready", 32'(in_ready), 32'd1);
    check("skid_recover_occ", 32'(occupancy), 32'd1);
    tick();
    check("skid_empty", 32'(out_valid), 32'd0);

    // Random traffic with a same-cycle independence probe on the handshake
    target = m_accepted + 1000;
    cyc = 0;
    while (m_accepted < target && cyc < 20000) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      #2;
      ir = in_ready; ov = out_valid; oc = occupancy;
      out_ready = ~out_ready;
      in_valid  = ~in_valid;
      #1;
      check("comb_in_ready", 32'(in_ready), 32'(ir));
      check("comb_out_valid", 32'(out_valid), 32'(ov));
      check("comb_occupancy", 32'(occupancy), 32'(oc));
      out_ready = ~out_ready;
      in_valid  = ~in_valid;
      cyc++;
    end
    check("random_done", 32'(m_accepted >= target), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1);
      tick();
    end
    check("random_drained", 32'(occupancy), 32'd0);

    // Reset asserted while FULL
    drive(1'b1, 32'h11, 1'b0);
    tick();
    drive(1'b1, 32'h22, 1'b0);
    tick();
    check("midrst_full", 32'(occupancy), 32'd2);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_occ", 32'(occupancy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_data", out_data, 32'd0);
    tick();
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    out_ready = 1'b1;
    tick();
    check("midrst_new_data", out_data, 32'h55);
    check("midrst_new_occ", 32'(occupancy), 32'd1);
    drive(1'b0, '0, 1'b1);
    tick();
    check("midrst_no_stale", 32'(out_valid), 32'd0);

    // Stall statistics
    drive(1'b1, 32'h77, 1'b0);
    tick();
    @(negedge clk);
    in_valid = 1'b0;
    stat_clr = 1'b1;
    tick();
    @(negedge clk);
    stat_clr = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("stall_20", 32'(stall_count), STATS ? 32'd20 : 32'd0);
    check("stall_20_w4", 32'(s_stall_count), STATS ? 32'd15 : 32'd0);
    @(negedge clk);
    stat_clr = 1'b1;
    tick();
    check("stall_clr", 32'(stall_count), 32'd0);
    check("stall_clr_w4", 32'(s_stall_count), 32'd0);
    @(negedge clk);
    stat_clr = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check("stall_40", 32'(stall_count), STATS ? 32'd40 : 32'd0);
    check("stall_40_sat_w4", 32'(s_stall_count), STATS ? 32'd15 : 32'd0);
    drive(1'b0, '0, 1'b1);
    tick();
    check("final_empty", 32'(occupancy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_skid_buffer.md
# stream_skid_buffer

Two-entry valid/ready register slice that registers both directions of the stream handshake. `out_valid` and `out_data` come straight from flops, and `in_ready` does too, so the slice cuts the backward ready path and the forward path. It sustains one transfer per cycle. It is inserted wherever a long `out_ready` combinational path from a downstream consumer must not reach the upstream producer.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width in bits
- STALL_CNT_W, 16, width of the stall counter (statistics build only)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream offers `in_data`
- in_ready  out  1  slice can accept; driven directly by a flop
- in_data  in  DATA_WIDTH  upstream payload
- out_valid  out  1  `out_data` is valid; driven directly by a flop
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  payload; driven directly by the output data register
- occupancy  out  2  number of held entries: 0, 1 or 2
- stat_clr  in  1  synchronous clear of `stall_count`
- stall_count  out  STALL_CNT_W  saturating count of cycles with `out_valid && !out_ready`

## Operation
- A transfer occurs on a port when valid and ready are both high at a rising edge.
- Storage:
  - `out_reg` is the output data register.
  - `skid_reg` is the overflow register.
- State machine:
  - EMPTY: occupancy 0, `in_ready` 1, `out_valid` 0.
  - BUSY: occupancy 1, `in_ready` 1, `out_valid` 1.
  - FULL: occupancy 2, `in_ready` 0, `out_valid` 1.
- EMPTY:
  - Input transfer: `out_reg` <= `in_data`, go to BUSY.
  - No input transfer: stay in EMPTY.
- BUSY:
  - Input and output transfer together: `out_reg` <= `in_data`, stay in BUSY.
  - Input transfer only: `skid_reg` <= `in_data`, go to FULL.
  - Output transfer only: go to EMPTY.
  - Neither: stay in BUSY.
- FULL:
  - Output transfer: `out_reg` <= `skid_reg`, go to BUSY.
  - Otherwise: stay in FULL. No input transfer is possible because `in_ready` is 0.
- `in_ready`, `out_valid` and `occupancy` are registered copies updated on the same edge as the state. None of them may depend combinationally on `out_ready` or `in_valid`.
- Ordering is strictly FIFO. No payload is dropped or duplicated.
- While `out_valid` is high and `out_ready` is low, `out_data` holds stable.
- Contents of `skid_reg` are don't-care outside FULL. Contents of `out_reg` are don't-care in EMPTY.

## Timing
- Reset values:
  - state EMPTY
  - `in_ready` 1
  - `out_valid` 0
  - `occupancy` 0
  - `out_data` 0
  - `skid_reg` 0
  - `stall_count` 0
- `in_valid` while `rst_n` is low is ignored.
- Latency: data accepted at edge N appears on `out_data` with `out_valid` high after edge N, so it is consumable at edge N+1.
- Throughput: one transfer per cycle in steady state with `out_ready` held high. The slice stays in BUSY.
- Backpressure: when `out_ready` falls, at most one extra beat is absorbed into `skid_reg`. `in_ready` drops one cycle after the stall, not in the same cycle.
- Recovery: from FULL, the first output transfer moves to BUSY, and `in_ready` returns to 1 on the next cycle.
- Reset asserted mid-operation: all held entries are discarded immediately and outputs go to their reset values asynchronously.

## Configuration
- Macro `STREAM_SKID_STATS_EN`.
- When defined:
  - `stall_count` increments by 1 each cycle with `out_valid && !out_ready`.
  - It saturates at all-ones.
  - `stat_clr` forces 0 on the next edge and takes priority over increment.
- When undefined:
  - No counter flops are built.
  - `stall_count` is tied to 0 and `stat_clr` is ignored.
- The port list is identical in both builds.

## Structure
- Shared package `stream_pkg`:
  - `skid_state_e` enum (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2)
  - default `STALL_CNT_W`
- One sub-module, `sat_counter`: a parameterised saturating counter with synchronous clear, instantiated only under `STREAM_SKID_STATS_EN`.

## Test plan
- Reset then idle: `rst_n` low for 3 cycles, no input → `in_ready`=1, `out_valid`=0, `occupancy`=0, `out_data`=0.
- Streaming: `out_ready`=1, send 0x1..0x8 on consecutive cycles → 0x1..0x8 appear in order one cycle after acceptance. `occupancy` stays 1 and no bubbles appear.
- Skid fill:
  - In BUSY holding 0xA, with `out_ready`=0, send 0xB → FULL, `occupancy`=2, `in_ready`=0 next cycle.
  - Raise `out_ready` → 0xA then 0xB are emitted.
- Random backpressure: 1000 beats of random data, `in_valid` and `out_ready` each 50% random → output sequence equals input sequence, and `in_ready` never depends on the same-cycle `out_ready`.
- Reset mid-FULL: assert `rst_n` low while in FULL → `out_valid`=0 and `occupancy`=0 immediately. After release, the first new beat 0x55 is output and no stale data appears.
- Stats build:
  - Hold `out_valid` with `out_ready`=0 for 20 cycles → `stall_count`=20.
  - `stat_clr` → 0.
  - With STALL_CNT_W=4, a 40-cycle stall → 15.
